// File: rtl/vram_arbiter.sv
// Single-port video SRAM sequencer: pixel fetches have absolute priority, and
// ISA reads/writes are posted into a one-entry buffer and launched only inside
// sequencer windows.
module vram_arbiter #(
  parameter int ACC_CYC = 2,
  parameter int WE_CYC  = 2,
  parameter int ADDR_W  = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  output logic              pix_err,
  input  logic              isa_op_enable,
  input  logic              isa_rd,
  input  logic              isa_wr,
  input  logic [ADDR_W-1:0] isa_addr,
  input  logic [7:0]        isa_din,
  output logic [7:0]        isa_dout,
  output logic              isa_busy,
  output logic              isa_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_oe,
  input  logic [7:0]        ram_din,
  output logic              ram_we_l
);

  typedef enum logic [2:0] {
    S_IDLE, S_PIX, S_ISA_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD
  } state_t;

  localparam logic [2:0] ACC_LAST = 3'(ACC_CYC - 1);
  localparam logic [2:0] WE_LAST  = 3'(WE_CYC - 1);

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg;
  logic              pend_valid_reg;
  logic [ADDR_W-1:0] pend_addr_reg;
  logic              isa_wr_reg;
  logic [ADDR_W-1:0] isa_addr_reg;
  logic [7:0]        isa_din_reg;
  logic [7:0]        pix_sample_reg;
  logic              pix_done_reg;

  logic              enter_pix, start_isa, op_last, pix_last;
  logic [ADDR_W-1:0] ram_a_next;
  logic [7:0]        ram_dout_next;
  logic              ram_oe_next, ram_we_l_next;

  // Next-state logic; a pixel strobe in the same cycle blocks an ISA start.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (pend_valid_reg)
          state_next = S_PIX;
        else if (isa_busy && isa_op_enable && !pix_req)
          state_next = isa_wr_reg ? S_WR_SETUP : S_ISA_RD;
      end
      S_PIX:      if (cnt_reg == ACC_LAST) state_next = S_IDLE;
      S_ISA_RD:   if (cnt_reg == ACC_LAST) state_next = pend_valid_reg ? S_PIX : S_IDLE;
      S_WR_SETUP: state_next = S_WR_PULSE;
      S_WR_PULSE: if (cnt_reg == WE_LAST) state_next = S_WR_HOLD;
      S_WR_HOLD:  state_next = pend_valid_reg ? S_PIX : S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // SRAM pin values are derived from the upcoming state so the pins are registered.
  always_comb begin
    enter_pix     = (state_next == S_PIX) && (state_reg != S_PIX);
    start_isa     = (state_reg == S_IDLE) &&
                    ((state_next == S_ISA_RD) || (state_next == S_WR_SETUP));
    pix_last      = (state_reg == S_PIX) && (cnt_reg == ACC_LAST);
    op_last       = ((state_reg == S_ISA_RD) && (cnt_reg == ACC_LAST)) ||
                    (state_reg == S_WR_HOLD);
    ram_a_next    = ram_a;
    ram_dout_next = ram_dout;
    if (enter_pix)
      ram_a_next = pend_addr_reg;
    else if (start_isa)
      ram_a_next = isa_addr_reg;
    if (start_isa && isa_wr_reg)
      ram_dout_next = isa_din_reg;
    ram_oe_next   = (state_next == S_WR_SETUP) || (state_next == S_WR_PULSE) ||
                    (state_next == S_WR_HOLD);
    ram_we_l_next = (state_next != S_WR_PULSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= 3'd0;
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= '0;
      isa_wr_reg     <= 1'b0;
      isa_addr_reg   <= '0;
      isa_din_reg    <= 8'd0;
      pix_sample_reg <= 8'd0;
      pix_done_reg   <= 1'b0;
      ram_a          <= '0;
      ram_dout       <= 8'd0;
      ram_oe         <= 1'b0;
      ram_we_l       <= 1'b1;
      pix_data       <= 8'd0;
      pix_valid      <= 1'b0;
      pix_err        <= 1'b0;
      isa_dout       <= 8'd0;
      isa_busy       <= 1'b0;
      isa_done       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= ((state_next == state_reg) && (state_reg != S_IDLE)) ? cnt_reg + 3'd1 : 3'd0;
      ram_a     <= ram_a_next;
      ram_dout  <= ram_dout_next;
      ram_oe    <= ram_oe_next;
      ram_we_l  <= ram_we_l_next;

      // The slot is freed at PIX entry, so a strobe on that edge refills it.
      if (pix_req) begin
        if (pend_valid_reg && !enter_pix) begin
          pix_err <= 1'b1;
        end else begin
          pend_valid_reg <= 1'b1;
          pend_addr_reg  <= pix_addr;
        end
      end else if (enter_pix) begin
        pend_valid_reg <= 1'b0;
      end

      pix_done_reg <= pix_last;
      if (pix_last)
        pix_sample_reg <= ram_din;
      pix_valid <= pix_done_reg;
      if (pix_done_reg)
        pix_data <= pix_sample_reg;

      isa_done <= op_last;
      if ((state_reg == S_ISA_RD) && (cnt_reg == ACC_LAST))
        isa_dout <= ram_din;
      if (op_last) begin
        isa_busy <= 1'b0;
      end else if (!isa_busy && (isa_rd || isa_wr)) begin
        isa_busy     <= 1'b1;
        isa_wr_reg   <= isa_wr;
        isa_addr_reg <= isa_addr;
        isa_din_reg  <= isa_din;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus a randomized run scored
// against a shadow memory and transaction-level timing rules.
module tb_vram_arbiter;
  localparam int AW = 19;
  localparam int ACC = 2;
  localparam int WEC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_req;
  logic [AW-1:0] pix_addr;
  logic [7:0]    pix_data;
  logic          pix_valid, pix_err;
  logic          isa_op_enable, isa_rd, isa_wr;
  logic [AW-1:0] isa_addr;
  logic [7:0]    isa_din, isa_dout;
  logic          isa_busy, isa_done;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_dout, ram_din;
  logic          ram_oe, ram_we_l;

  vram_arbiter #(.ACC_CYC(ACC), .WE_CYC(WEC), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .pix_req(pix_req), .pix_addr(pix_addr), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_err(pix_err),
    .isa_op_enable(isa_op_enable), .isa_rd(isa_rd), .isa_wr(isa_wr),
    .isa_addr(isa_addr), .isa_din(isa_din), .isa_dout(isa_dout),
    .isa_busy(isa_busy), .isa_done(isa_done),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_oe(ram_oe),
    .ram_din(ram_din), .ram_we_l(ram_we_l)
  );

  always #5 clk = ~clk;

  // SRAM environment and the bench's own expected memory contents
  logic [7:0] mem    [0:(1<<AW)-1];
  logic [7:0] shadow [0:(1<<AW)-1];
  assign ram_din = mem[ram_a];
  always @(posedge clk) if (!ram_we_l) mem[ram_a] <= ram_dout;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Write-strobe safety: address/data frozen and bus driven while ram_we_l is low
  logic [AW-1:0] prev_a;
  logic [7:0]    prev_dout;
  always @(negedge clk) begin
    if (ram_we_l === 1'b0) begin
      check("we_addr_stable", 32'(ram_a), 32'(prev_a));
      check("we_data_stable", 32'(ram_dout), 32'(prev_dout));
      check("we_oe_high", 32'(ram_oe), 32'd1);
    end
    prev_a    = ram_a;
    prev_dout = ram_dout;
  end

  int n_we, n_oe, n_done, n_pv, pv_cyc, done_cyc;
  logic [7:0] pv_data;

  task automatic clear_counts();
    n_we = 0; n_oe = 0; n_done = 0; n_pv = 0; pv_cyc = -1; done_cyc = -1; pv_data = 8'd0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (!ram_we_l) n_we++;
    if (ram_oe) n_oe++;
    if (isa_done) begin n_done++; done_cyc = cyc; end
    if (pix_valid) begin
      n_pv++;
      if (pv_cyc < 0) begin pv_cyc = cyc; pv_data = pix_data; end
    end
  endtask

  task automatic observe(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_pulse();
    int k = 0;
    while (ram_we_l && k < 10) begin tick(); k++; end
    check("wait_pulse_seen", 32'(!ram_we_l), 32'd1);
  endtask

  task automatic isa_strobe(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
    isa_rd = rd; isa_wr = wr; isa_addr = a; isa_din = d;
    tick();
    isa_rd = 1'b0; isa_wr = 1'b0;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37) ^ (i >> 7));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] pq[$];
  int            pt[$];

  initial begin
    int issue, gap;
    logic outstanding, exp_read;
    logic [7:0] exp_data, d;
    logic [AW-1:0] a, a0;

    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = pat(i);
      shadow[i] = pat(i);
    end
    reset = 1'b1; pix_req = 1'b0; pix_addr = '0; isa_op_enable = 1'b0;
    isa_rd = 1'b0; isa_wr = 1'b0; isa_addr = '0; isa_din = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_we_l", 32'(ram_we_l), 32'd1);
    check("rst_oe", 32'(ram_oe), 32'd0);
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_ram_dout", 32'(ram_dout), 32'd0);
    check("rst_pix", 32'({pix_valid, pix_err, pix_data}), 32'd0);
    check("rst_isa", 32'({isa_busy, isa_done, isa_dout}), 32'd0);
    reset = 1'b0;
    tick();

    // Uncontended pixel fetch
    mem[19'h00123] = 8'h5A; shadow[19'h00123] = 8'h5A;
    clear_counts();
    pix_req = 1'b1; pix_addr = 19'h00123; issue = cyc + 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      pix_req = 1'b0;
      if (k == 1) check("pix_a_before", 32'(ram_a), 32'd0);
      if (k == 2 || k == 3) check("pix_a_held", 32'(ram_a), 32'h00123);
    end
    check("pix_count", 32'(n_pv), 32'd1);
    check("pix_latency", 32'(pv_cyc - issue), 32'(ACC + 2));
    check("pix_data", 32'(pv_data), 32'h5A);

    // ISA write inside an open window
    isa_op_enable = 1'b1;
    clear_counts();
    isa_strobe(1'b0, 1'b1, 19'h04000, 8'hC3);
    shadow[19'h04000] = 8'hC3;
    check("wr_busy_set", 32'(isa_busy), 32'd1);
    observe(10);
    check("wr_we_cycles", 32'(n_we), 32'(WEC));
    check("wr_oe_cycles", 32'(n_oe), 32'(WEC + 2));
    check("wr_done", 32'(n_done), 32'd1);
    check("wr_mem", 32'(mem[19'h04000]), 32'hC3);
    check("wr_busy_clr", 32'(isa_busy), 32'd0);

    // ISA read held off by a closed window
    isa_op_enable = 1'b0;
    clear_counts();
    isa_strobe(1'b1, 1'b0, 19'h04000, 8'h00);
    a0 = ram_a;
    observe(10);
    check("rd_wait_oe", 32'(n_oe), 32'd0);
    check("rd_wait_done", 32'(n_done), 32'd0);
    check("rd_wait_addr", 32'(ram_a), 32'(a0));
    check("rd_wait_busy", 32'(isa_busy), 32'd1);
    isa_op_enable = 1'b1;
    clear_counts();
    observe(8);
    check("rd_done", 32'(n_done), 32'd1);
    check("rd_dout", 32'(isa_dout), 32'hC3);
    check("rd_busy_clr", 32'(isa_busy), 32'd0);

    // Pixel request during the write pulse is served right after the write
    clear_counts();
    isa_strobe(1'b0, 1'b1, 19'h04001, 8'h3C);
    shadow[19'h04001] = 8'h3C;
    wait_pulse();
    pix_req = 1'b1; pix_addr = 19'h00200; issue = cyc + 1;
    tick();
    pix_req = 1'b0;
    observe(12);
    check("c_we_cycles", 32'(n_we), 32'(WEC));
    check("c_done", 32'(n_done), 32'd1);
    check("c_pix_count", 32'(n_pv), 32'd1);
    check("c_pix_lat_ok", 32'(pv_cyc > issue && pv_cyc - issue <= WEC + ACC + 4), 32'd1);
    check("c_pix_after_hold", 32'(pv_cyc - done_cyc), 32'(ACC + 1));
    check("c_pix_data", 32'(pv_data), 32'(shadow[19'h00200]));
    check("c_pix_err", 32'(pix_err), 32'd0);
    check("c_mem", 32'(mem[19'h04001]), 32'h3C);

    // Overrun: second request while the slot is full is dropped
    clear_counts();
    isa_strobe(1'b0, 1'b1, 19'h04005, 8'hA5);
    shadow[19'h04005] = 8'hA5;
    wait_pulse();
    pix_req = 1'b1; pix_addr = 19'h00300;
    tick();
    pix_addr = 19'h00301;
    tick();
    pix_req = 1'b0;
    observe(14);
    check("ovr_err", 32'(pix_err), 32'd1);
    check("ovr_pix_count", 32'(n_pv), 32'd1);
    check("ovr_pix_data", 32'(pv_data), 32'(shadow[19'h00300]));
    observe(5);
    check("ovr_err_sticky", 32'(pix_err), 32'd1);

    // Reset in the middle of a write pulse
    clear_counts();
    isa_strobe(1'b0, 1'b1, 19'h04002, 8'h99);
    wait_pulse();
    reset = 1'b1;
    tick();
    check("mr_we_l", 32'(ram_we_l), 32'd1);
    check("mr_oe", 32'(ram_oe), 32'd0);
    check("mr_busy", 32'(isa_busy), 32'd0);
    check("mr_done", 32'(isa_done), 32'd0);
    check("mr_err_clr", 32'(pix_err), 32'd0);
    reset = 1'b0;
    clear_counts();
    observe(6);
    check("mr_no_done", 32'(n_done), 32'd0);

    // Simultaneous read+write strobe performs only the write
    clear_counts();
    isa_strobe(1'b1, 1'b1, 19'h04003, 8'h77);
    shadow[19'h04003] = 8'h77;
    observe(10);
    check("rw_we_cycles", 32'(n_we), 32'(WEC));
    check("rw_done", 32'(n_done), 32'd1);
    check("rw_mem", 32'(mem[19'h04003]), 32'h77);
    check("rw_no_read", 32'(isa_dout), 32'd0);

    // Randomized traffic against the shadow-memory scoreboard
    gap = 20; outstanding = 1'b0; exp_read = 1'b0; exp_data = 8'd0;
    for (int c = 0; c < 1600; c++) begin
      pix_req = 1'b0; isa_rd = 1'b0; isa_wr = 1'b0;
      isa_op_enable = (c >= 1400) ? 1'b1 : ($urandom_range(0, 9) < 7);
      if (c < 1400 && gap >= 9 && $urandom_range(0, 3) == 0) begin
        a = AW'($urandom_range(0, 'h3FFF));
        pix_req = 1'b1; pix_addr = a;
        pq.push_back(a); pt.push_back(cyc + 1);
        gap = 0;
      end else begin
        gap++;
      end
      if (c < 1400 && !outstanding && $urandom_range(0, 2) == 0) begin
        a = AW'('h4010 + $urandom_range(0, 15));
        isa_addr = a;
        if ($urandom_range(0, 1) == 1) begin
          d = 8'($urandom);
          isa_wr = 1'b1; isa_din = d;
          isa_rd = ($urandom_range(0, 3) == 0);
          shadow[a] = d; exp_read = 1'b0;
        end else begin
          isa_rd = 1'b1; exp_read = 1'b1; exp_data = shadow[a];
        end
        outstanding = 1'b1;
      end
      @(negedge clk);
      if (pix_valid) begin
        if (pq.size() == 0) begin
          check("rnd_spurious_pix", 32'd1, 32'd0);
        end else begin
          a = pq.pop_front();
          issue = pt.pop_front();
          check("rnd_pix_data", 32'(pix_data), 32'(shadow[a]));
          check("rnd_pix_lat_ok", 32'(cyc - issue >= ACC + 2 && cyc - issue <= WEC + ACC + 4), 32'd1);
        end
      end
      if (isa_done) begin
        if (!outstanding) begin
          check("rnd_spurious_done", 32'd1, 32'd0);
        end else begin
          if (exp_read) check("rnd_isa_dout", 32'(isa_dout), 32'(exp_data));
          outstanding = 1'b0;
        end
      end
      check("rnd_busy", 32'(isa_busy), 32'(outstanding));
    end
    check("rnd_pix_drained", 32'(pq.size()), 32'd0);
    check("rnd_isa_drained", 32'(outstanding), 32'd0);
    check("rnd_pix_err", 32'(pix_err), 32'd0);
    for (int i = 'h4010; i < 'h4020; i++)
      check("rnd_mem_final", 32'(mem[i]), 32'(shadow[i]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sequences every access to the single external video SRAM and shares it between two requesters: the pixel fetch path (sequencer-timed) and the ISA memory path (host CPU reads/writes).
- Sits between the sequencer/pixel pusher/ISA decode and the SRAM pins.
- Pixel fetches have absolute priority.
- ISA operations are posted into a one-entry buffer and launched only inside sequencer-granted windows.

Parameters:
- ACC_CYC, 2, SRAM read access length in clk cycles (1..7). Address is held stable this long before data is sampled.
- WE_CYC, 2, width of the ram_we_l low pulse in clk cycles (1..7).
- ADDR_W, 19, SRAM address width.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pix_req  in  1  one-cycle strobe: fetch byte at pix_addr
- pix_addr  in  ADDR_W  pixel fetch address, sampled with pix_req
- pix_data  out  8  fetched byte, valid while pix_valid=1
- pix_valid  out  1  one-cycle pulse, pixel data ready
- pix_err  out  1  sticky: pixel request lost (overrun)
- isa_op_enable  in  1  sequencer window; ISA op may start only when high
- isa_rd  in  1  one-cycle strobe: ISA read request
- isa_wr  in  1  one-cycle strobe: ISA write request
- isa_addr  in  ADDR_W  ISA address, sampled with strobe
- isa_din  in  8  ISA write data, sampled with isa_wr
- isa_dout  out  8  read data, held until the next ISA read completes
- isa_busy  out  1  buffer occupied; new strobes ignored
- isa_done  out  1  one-cycle pulse, ISA op finished
- ram_a  out  ADDR_W  SRAM address
- ram_dout  out  8  SRAM write data
- ram_oe  out  1  1 = drive ram_dout onto SRAM data bus
- ram_din  in  8  SRAM read data
- ram_we_l  out  1  SRAM write enable, active low

Behaviour:
- Reset values: ram_we_l=1, ram_oe=0, ram_a=0, ram_dout=0, pix_valid=0, pix_data=0, pix_err=0, isa_busy=0, isa_done=0, isa_dout=0. State=IDLE; pixel-pending and ISA buffers cleared.
- Reset mid-operation: ram_we_l goes high at that edge, no pulses issued, and the in-flight op is discarded.
- All outputs are registered.
- States: IDLE, PIX, ISA_RD, WR_SETUP, WR_PULSE, WR_HOLD.
- Pixel pending:
  - pix_req is latched into a one-deep pending slot (addr + flag).
  - If pix_req arrives while the slot is already full, the new request is dropped and pix_err sets (cleared only by reset).
- IDLE priority:
  - (1) Pending pixel -> PIX.
  - (2) Else, ISA buffer full and isa_op_enable=1 -> ISA_RD or WR_SETUP.
  - (3) Else stay in IDLE.
- A pix_req arriving in the same cycle as an ISA start wins: the ISA op waits.
- PIX:
  - ram_a=pixel addr for ACC_CYC cycles.
  - ram_din is sampled on the last cycle; pix_data/pix_valid register the next edge.
  - Uncontended latency: pix_req at edge N -> pix_valid high in cycle N+ACC_CYC+2.
  - Return to IDLE; the pending slot clears on entry to PIX.
- ISA_RD: ACC_CYC cycles, then isa_dout<=ram_din, isa_done pulses, isa_busy clears the same edge, -> IDLE.
- Writes:
  - WR_SETUP (1 cycle): ram_a, ram_dout, ram_oe=1.
  - WR_PULSE (WE_CYC cycles): ram_we_l=0.
  - WR_HOLD (1 cycle): ram_we_l=1, ram_oe=1, address and data still held.
  - Then ram_oe=0, isa_done pulses, isa_busy clears, -> IDLE.
- ISA ops are non-abortable. A pixel request during an ISA op goes to pending and is served immediately after. Worst-case pixel latency = WE_CYC+2+ACC_CYC+2 cycles.
- ram_oe is high only in WR_SETUP/WR_PULSE/WR_HOLD. ram_we_l is never low while ram_a or ram_dout changes.
- ISA strobes:
  - Accepted only when isa_busy=0; isa_busy rises the next edge.
  - isa_rd and isa_wr in the same cycle: the write is taken and the read ignored.
  - Strobes while busy are ignored with no flag.
- A counter inside each state counts up to ACC_CYC-1 or WE_CYC-1, is 3 bits wide, and clears on state exit.

Test Plan:
- Reset, then single pix_req at addr 0x00123 with the SRAM model returning 0x5A (ACC_CYC=2) -> ram_a=0x00123 for 2 cycles; pix_valid one cycle with pix_data=0x5A, exactly 4 cycles after the strobe.
- isa_wr addr 0x04000 data 0xC3 with isa_op_enable=1 -> isa_busy=1; setup 1 cycle, ram_we_l low 2 cycles, hold 1 cycle; addr/data stable throughout; isa_done pulse; memory model holds 0xC3.
- isa_rd addr 0x04000 with isa_op_enable held low 10 cycles, then high -> no SRAM activity until the window; then isa_dout=0xC3 and isa_done; isa_busy low afterwards.
- pix_req issued during WR_PULSE -> write completes unbroken; PIX starts the next cycle after WR_HOLD; pix_valid arrives within 8 cycles; pix_err stays 0.
- Two pix_req while the pending slot is full (during ISA write) -> second request dropped, pix_err=1 and sticky; only one pix_valid.
- Reset asserted in WR_PULSE -> ram_we_l=1 and ram_oe=0 the next cycle, no isa_done, isa_busy=0; a simultaneous isa_rd+isa_wr afterwards performs only the write.
